// File: rtl/scu_pkg.sv
// Shared definitions for the SCU work sequencer: grid and index-width
// defaults, derived coordinate widths, the sequencer state encoding and a
// golden ceiling-division helper.
package scu_pkg;

   localparam int POF_DEFAULT       = 4;
   localparam int PIF_DEFAULT       = 12;
   localparam int IDX_WIDTH_DEFAULT = 16;

   localparam int ROW_W = $clog2(POF_DEFAULT);
   localparam int COL_W = $clog2(PIF_DEFAULT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIV,
      ST_RANGE,
      ST_EMIT,
      ST_DONE
   } seq_state_t;

   // Reference ceil(num/den); a zero divisor yields zero.
   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      if (den == 0) begin
         return 0;
      end
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/seq_ceil_div.sv
// Restoring divider producing ceil(dividend/divisor) in exactly WIDTH cycles.
// done is high during the final iteration; quotient is valid from the next
// cycle on and holds until the following start.
module seq_ceil_div #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] work;
   logic [CNT_W-1:0] count;
   logic             running;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] work_next;

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor when it fits, recording the quotient bit.
   always_comb begin
      shifted   = {rem[WIDTH-1:0], work[WIDTH-1]};
      rem_next  = shifted;
      work_next = {work[WIDTH-2:0], 1'b0};
      if (shifted >= {1'b0, divisor}) begin
         rem_next  = shifted - {1'b0, divisor};
         work_next = {work[WIDTH-2:0], 1'b1};
      end
      done = running && (count == CNT_W'(1));
   end

   // Iteration control; the last step rounds the quotient up when a
   // remainder is left over.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem      <= '0;
         work     <= '0;
         count    <= '0;
         running  <= 1'b0;
         quotient <= '0;
      end else if (start) begin
         rem      <= '0;
         work     <= dividend;
         count    <= CNT_W'(WIDTH);
         running  <= 1'b1;
         quotient <= '0;
      end else if (running) begin
         rem   <= rem_next;
         work  <= work_next;
         count <= count - CNT_W'(1);
         if (count == CNT_W'(1)) begin
            running  <= 1'b0;
            quotient <= work_next + WIDTH'(rem_next != '0);
         end
      end
   end

endmodule

// File: rtl/scu_work_sequencer.sv
// Streams every (out_idx, in_idx) pair owned by one SCU of the POF x PIF
// grid, out-major with in_idx innermost, over a valid/ready handshake.
// Ownership follows the mapper rule: row = out_idx/ceil(out_ch/POF),
// col = in_idx/ceil(in_ch/PIF).
module scu_work_sequencer
   import scu_pkg::*;
#(
   parameter int POF       = POF_DEFAULT,
   parameter int PIF       = PIF_DEFAULT,
   parameter int IDX_WIDTH = IDX_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [IDX_WIDTH-1:0]    out_ch,
   input  logic [IDX_WIDTH-1:0]    in_ch,
   input  logic [$clog2(POF)-1:0]  scu_row,
   input  logic [$clog2(PIF)-1:0]  scu_col,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [IDX_WIDTH-1:0]    out_idx,
   output logic [IDX_WIDTH-1:0]    in_idx,
   output logic                    row_last,
   output logic                    last,
   output logic                    done
);

   localparam int RW = $clog2(POF);
   localparam int CW = $clog2(PIF);
   localparam int AW = IDX_WIDTH + CW + 1;

   seq_state_t state;

   logic [IDX_WIDTH-1:0] out_ch_q;
   logic [IDX_WIDTH-1:0] in_ch_q;
   logic [RW-1:0]        row_q;
   logic [CW-1:0]        col_q;

   logic [IDX_WIDTH-1:0] o_last;
   logic [IDX_WIDTH-1:0] i_lo;
   logic [IDX_WIDTH-1:0] i_last;

   logic                 div_start;
   logic                 opr_done;
   logic                 ipc_done;
   logic [IDX_WIDTH-1:0] opr;
   logic [IDX_WIDTH-1:0] ipc;

   logic [AW-1:0]        o_lo_c;
   logic [AW-1:0]        o_end_c;
   logic [AW-1:0]        o_hi_c;
   logic [AW-1:0]        i_lo_c;
   logic [AW-1:0]        i_end_c;
   logic [AW-1:0]        i_hi_c;
   logic                 range_empty;
   logic                 first_row_last;
   logic                 first_last;

   logic [IDX_WIDTH-1:0] out_next;
   logic [IDX_WIDTH-1:0] in_next;
   logic                 row_last_next;
   logic                 last_next;

   assign div_start = (state == ST_IDLE) && start;

   seq_ceil_div #(.WIDTH(IDX_WIDTH)) u_opr_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (out_ch),
      .divisor  (IDX_WIDTH'(POF)),
      .done     (opr_done),
      .quotient (opr)
   );

   seq_ceil_div #(.WIDTH(IDX_WIDTH)) u_ipc_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (in_ch),
      .divisor  (IDX_WIDTH'(PIF)),
      .done     (ipc_done),
      .quotient (ipc)
   );

   // Range bounds for this SCU in widened arithmetic so that lo+per never
   // wraps before it is clipped against the channel count.
   always_comb begin
      o_lo_c  = AW'(row_q) * AW'(opr);
      o_end_c = o_lo_c + AW'(opr);
      o_hi_c  = (o_end_c < AW'(out_ch_q)) ? o_end_c : AW'(out_ch_q);
      i_lo_c  = AW'(col_q) * AW'(ipc);
      i_end_c = i_lo_c + AW'(ipc);
      i_hi_c  = (i_end_c < AW'(in_ch_q)) ? i_end_c : AW'(in_ch_q);
      range_empty = (o_lo_c >= o_hi_c) || (i_lo_c >= i_hi_c) ||
                    (AW'(col_q) >= AW'(PIF)) ||
                    (out_ch_q == '0) || (in_ch_q == '0);
      first_row_last = (i_lo_c == i_hi_c - AW'(1));
      first_last     = first_row_last && (o_lo_c == o_hi_c - AW'(1));
   end

   // Position of the beat following the current one, with its flags.
   always_comb begin
      in_next  = in_idx + IDX_WIDTH'(1);
      out_next = out_idx;
      if (row_last) begin
         in_next  = i_lo;
         out_next = out_idx + IDX_WIDTH'(1);
      end
      row_last_next = (in_next == i_last);
      last_next     = row_last_next && (out_next == o_last);
   end

   // Job control: latch the job, wait for the dividers, set up the range,
   // stream beats on handshakes and pulse done once at the end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_ch_q  <= '0;
         in_ch_q   <= '0;
         row_q     <= '0;
         col_q     <= '0;
         o_last    <= '0;
         i_lo      <= '0;
         i_last    <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         in_idx    <= '0;
         row_last  <= 1'b0;
         last      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  out_ch_q <= out_ch;
                  in_ch_q  <= in_ch;
                  row_q    <= scu_row;
                  col_q    <= scu_col;
                  busy     <= 1'b1;
                  state    <= ST_DIV;
               end
            end
            ST_DIV: begin
               if (opr_done && ipc_done) begin
                  state <= ST_RANGE;
               end
            end
            ST_RANGE: begin
               o_last <= IDX_WIDTH'(o_hi_c - AW'(1));
               i_lo   <= IDX_WIDTH'(i_lo_c);
               i_last <= IDX_WIDTH'(i_hi_c - AW'(1));
               if (range_empty) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  out_idx   <= IDX_WIDTH'(o_lo_c);
                  in_idx    <= IDX_WIDTH'(i_lo_c);
                  row_last  <= first_row_last;
                  last      <= first_last;
                  out_valid <= 1'b1;
                  state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_valid && out_ready) begin
                  if (last) begin
                     out_valid <= 1'b0;
                     row_last  <= 1'b0;
                     last      <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     out_idx  <= out_next;
                     in_idx   <= in_next;
                     row_last <= row_last_next;
                     last     <= last_next;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
